// File: rtl/lpcm_pkg.sv
// Shared LPCM types: request item, responder FIFO entry, default latency clamp and clamp helper.
package lpcm_pkg;

    typedef struct packed {
        int sample;
        int latency;
    } lpcm_item;

    typedef struct packed {
        int          sample;
        int unsigned lat;
        int unsigned stamp;
    } lpcm_rsp_entry_t;

    localparam int unsigned LPCM_MAX_LAT_DEFAULT = 255;

    // Requested latency is signed; anything below one cycle is forced to one.
    function automatic int unsigned lpcm_clamp_latency(input int latency, input int unsigned max_lat);
        if (latency < 1)
            return 1;
        else if ($unsigned(latency) > max_lat)
            return max_lat;
        else
            return $unsigned(latency);
    endfunction

endpackage

// File: rtl/lpcm_rsp_fifo.sv
// Generic DEPTH x lpcm_rsp_entry_t synchronous FIFO; pointers carry an extra wrap bit for full/empty.
module lpcm_rsp_fifo
    import lpcm_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  lpcm_rsp_entry_t din,
    output lpcm_rsp_entry_t head,
    output logic            full,
    output logic            empty
);

    localparam int AW = $clog2(DEPTH);

    lpcm_rsp_entry_t mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/lpcm_responder.sv
// LPCM responder: queues requests in order, releases each after its clamped latency through one output register.
// Optional LPCM_RSP_PEAK_EN adds a peak_abs tracker over delivered samples plus a per-response $display.
module lpcm_responder
    import lpcm_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter int          BITS        = 32,
    parameter int unsigned MAX_LATENCY = LPCM_MAX_LAT_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_en,
    input  lpcm_item    req,
    output logic        rsp_en,
    output logic        rsp_valid,
    output lpcm_item    rsp,
    input  logic        rsp_ready,
    output logic        fmt_err,
    output logic [31:0] count,
    output logic        idle
`ifdef LPCM_RSP_PEAK_EN
    ,
    output logic [31:0] peak_abs
`endif
);

    // Bits below the left-justified sample must be zero; mask is empty at BITS=32.
    localparam logic [31:0] FMT_MASK = 32'((64'd1 << (32 - BITS)) - 64'd1);

    logic [31:0]     now;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            head_elig;
    logic            drain;
    lpcm_rsp_entry_t wr_entry;
    lpcm_rsp_entry_t head;

    assign rsp_en    = !fifo_full;
    assign push      = req_en && rsp_en;
    assign drain     = rsp_valid && rsp_ready;
    assign head_elig = !fifo_empty && ((now - head.stamp) >= head.lat);
    assign pop       = head_elig && (!rsp_valid || rsp_ready);
    assign idle      = fifo_empty && !rsp_valid;

    always_comb begin
        wr_entry.sample = req.sample;
        wr_entry.lat    = lpcm_clamp_latency(req.latency, MAX_LATENCY);
        wr_entry.stamp  = now;
    end

    lpcm_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (wr_entry),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output register reloads on the same edge it drains, so back-to-back items flow at one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now       <= '0;
            rsp_valid <= 1'b0;
            rsp       <= '0;
            fmt_err   <= 1'b0;
            count     <= '0;
        end else begin
            now <= now + 32'd1;
            if (pop) begin
                rsp_valid   <= 1'b1;
                rsp.sample  <= head.sample;
                rsp.latency <= int'(head.lat);
            end else if (drain) begin
                rsp_valid <= 1'b0;
            end
            if (drain)
                count <= count + 32'd1;
            if (push && (($unsigned(req.sample) & FMT_MASK) != 32'd0))
                fmt_err <= 1'b1;
        end
    end

`ifdef LPCM_RSP_PEAK_EN
    logic [31:0] rsp_abs;

    // Magnitude of the most negative sample does not fit, so it saturates.
    always_comb begin
        rsp_abs = $unsigned(rsp.sample);
        if (rsp.sample < 0)
            rsp_abs = $unsigned(-rsp.sample);
        if (rsp_abs[31])
            rsp_abs = 32'h7FFF_FFFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_abs <= '0;
        end else if (drain) begin
            if (rsp_abs > peak_abs)
                peak_abs <= rsp_abs;
            $display("recv sample: %0d, latency: %0d", rsp.sample, rsp.latency);
        end
    end
`endif

endmodule

// File: tb/tb_lpcm_responder.sv
// Directed self-checking bench for lpcm_responder; a second BITS=16 instance covers format checking.
module tb_lpcm_responder;
    import lpcm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_en = 1'b0;
    lpcm_item    req = '0;
    logic        rsp_en;
    logic        rsp_valid;
    lpcm_item    rsp;
    logic        rsp_ready = 1'b1;
    logic        fmt_err;
    logic [31:0] count;
    logic        idle;

    logic        f_req_en = 1'b0;
    lpcm_item    f_req = '0;
    logic        f_rsp_en;
    logic        f_rsp_valid;
    lpcm_item    f_rsp;
    logic        f_rsp_ready = 1'b1;
    logic        f_fmt_err;
    logic [31:0] f_count;
    logic        f_idle;

`ifdef LPCM_RSP_PEAK_EN
    logic [31:0] peak_abs;
    logic [31:0] f_peak_abs;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lpcm_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_en    (req_en),
        .req       (req),
        .rsp_en    (rsp_en),
        .rsp_valid (rsp_valid),
        .rsp       (rsp),
        .rsp_ready (rsp_ready),
        .fmt_err   (fmt_err),
        .count     (count),
        .idle      (idle)
`ifdef LPCM_RSP_PEAK_EN
        ,
        .peak_abs  (peak_abs)
`endif
    );

    lpcm_responder #(.BITS(16)) dut_fmt (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_en    (f_req_en),
        .req       (f_req),
        .rsp_en    (f_rsp_en),
        .rsp_valid (f_rsp_valid),
        .rsp       (f_rsp),
        .rsp_ready (f_rsp_ready),
        .fmt_err   (f_fmt_err),
        .count     (f_count),
        .idle      (f_idle)
`ifdef LPCM_RSP_PEAK_EN
        ,
        .peak_abs  (f_peak_abs)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Called at a negedge; the request is taken on the following posedge, returns at the next negedge.
    task automatic applyStimulus(input int sample, input int latency);
        checkOutput("accept_ready", {31'd0, rsp_en}, 32'd1);
        req_en      = 1'b1;
        req.sample  = sample;
        req.latency = latency;
        @(negedge clk);
        req_en = 1'b0;
    endtask

    task automatic waitValid(input int limit, output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int accepted;
        int seen;
        int exp_q[$];
        int got_q[$];
        int t2_lat[3] = '{0, -5, 1000};
        int t2_exp[3] = '{1, 1, 255};

        // Reset state
        @(negedge clk);
        checkOutput("rst_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_sample", rsp.sample, 32'd0);
        checkOutput("rst_latency", rsp.latency, 32'd0);
        checkOutput("rst_idle", {31'd0, idle}, 32'd1);
        checkOutput("rst_count", count, 32'd0);
        checkOutput("rst_fmt", {31'd0, fmt_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_en", {31'd0, rsp_en}, 32'd1);

        // Single item with latency 3
        applyStimulus(32'h1234_0000, 3);
        waitValid(20, cyc);
        checkOutput("t1_delay", cyc, 32'd3);
        checkOutput("t1_sample", rsp.sample, 32'h1234_0000);
        checkOutput("t1_latency", rsp.latency, 32'd3);
        @(negedge clk);
        checkOutput("t1_count", count, 32'd1);
        checkOutput("t1_valid_drop", {31'd0, rsp_valid}, 32'd0);
        checkOutput("t1_idle", {31'd0, idle}, 32'd1);

        // Latency clamp at both ends
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h0100_0000 * (i + 1), t2_lat[i]);
            waitValid(400, cyc);
            checkOutput("t2_delay", cyc, t2_exp[i]);
            checkOutput("t2_latency", rsp.latency, t2_exp[i]);
            @(negedge clk);
        end
        checkOutput("t2_count", count, 32'd4);

        // Ordering and backpressure
        applyReset();
        checkOutput("t3_count_rst", count, 32'd0);
        rsp_ready = 1'b0;
        applyStimulus(32'hA000_0000, 10);
        applyStimulus(32'hB000_0000, 1);
        applyStimulus(32'hC000_0000, 1);
        exp_q = '{32'hA000_0000, 32'hB000_0000, 32'hC000_0000};
        accepted = 3;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_en) break;
            req_en      = 1'b1;
            req.sample  = 32'h1000_0000 + i * 32'h0001_0000;
            req.latency = 1;
            exp_q.push_back(req.sample);
            @(negedge clk);
            req_en = 1'b0;
            accepted++;
        end
        checkOutput("t3_full_en", {31'd0, rsp_en}, 32'd0);
        checkOutput("t3_accepted", accepted, 32'd8);
        waitValid(30, cyc);
        checkOutput("t3_head_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("t3_head_sample", rsp.sample, 32'hA000_0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("t3_hold_sample", rsp.sample, 32'hA000_0000);
        end
        checkOutput("t3_slot_free", {31'd0, rsp_en}, 32'd1);
        applyStimulus(32'hD000_0000, 1);
        exp_q.push_back(32'hD000_0000);
        checkOutput("t3_full_again", {31'd0, rsp_en}, 32'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) got_q.push_back(rsp.sample);
            @(negedge clk);
        end
        checkOutput("t3_num_rsp", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            checkOutput("t3_order", (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF, exp_q[i]);
        checkOutput("t3_count", count, 32'd9);
        checkOutput("t3_idle", {31'd0, idle}, 32'd1);

        // Format checking: BITS=16 instance and BITS=32 instance
        f_req_en       = 1'b1;
        f_req.sample   = 32'h7FFF_0000;
        f_req.latency  = 1;
        @(negedge clk);
        f_req_en = 1'b0;
        @(negedge clk);
        checkOutput("t4_fmt_ok", {31'd0, f_fmt_err}, 32'd0);
        f_req_en       = 1'b1;
        f_req.sample   = 32'h0000_0001;
        @(negedge clk);
        f_req_en = 1'b0;
        checkOutput("t4_fmt_set", {31'd0, f_fmt_err}, 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("t4_fmt_sticky", {31'd0, f_fmt_err}, 32'd1);
        applyStimulus(32'h0000_0001, 1);
        repeat (3) @(negedge clk);
        checkOutput("t4_fmt_bits32", {31'd0, fmt_err}, 32'd0);

        // Reset with items queued
        for (int i = 0; i < 4; i++)
            applyStimulus(32'h2000_0000 + i, 20);
        checkOutput("t5_busy", {31'd0, idle}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t5_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("t5_idle", {31'd0, idle}, 32'd1);
        checkOutput("t5_count", count, 32'd0);
        checkOutput("t5_fmt_clr", {31'd0, f_fmt_err}, 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checkOutput("t5_stale", seen, 32'd0);
        checkOutput("t5_en", {31'd0, rsp_en}, 32'd1);

`ifdef LPCM_RSP_PEAK_EN
        // Peak magnitude with saturation of the most negative value
        applyReset();
        checkOutput("t6_peak_rst", peak_abs, 32'd0);
        applyStimulus(-5, 1);
        applyStimulus(32'h8000_0000, 1);
        applyStimulus(7, 1);
        repeat (6) @(negedge clk);
        checkOutput("t6_count", count, 32'd3);
        checkOutput("t6_peak", peak_abs, 32'h7FFF_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
